imem_fetch_unit: RTL and testbench

Sequencer that drives the byte-addressed, combinational-read instruction memory (512 bytes, big-endian 4-byte word assembly) on behalf of the processor front end. It owns the program counter and issues one word fetch per cycle. It buffers fetched words in a small FIFO and hands them to decode through a valid/ready handshake. It handles branch redirects and flags fetches from illegal addresses.

---
 rtl/imem_fetch_unit_pkg.sv | 29 ++
 rtl/imem_fetch_unit_fifo.sv | 72 +++++++
 rtl/imem_fetch_unit.sv | 118 +++++++++++
 tb/tb_imem_fetch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its memory.
package imem_fetch_unit_pkg;

    localparam int INST_W            = 32;
    localparam int ADDR_W            = 32;
    localparam int MEM_BYTES_DEFAULT = 512;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FAULT
    } fetch_state_e;

    // One buffered fetch: the address it came from and the word read there.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // A fetch address is usable only when word aligned and the whole word
    // lies inside the memory.
    function automatic logic fetch_addr_legal(input logic [ADDR_W-1:0] addr,
                                              input int unsigned       mem_bytes);
        logic [ADDR_W-1:0] last_word;
        last_word = ADDR_W'(mem_bytes - 4);
        return (addr[1:0] == 2'b00) && (addr <= last_word);
    endfunction

endpackage

// File: rtl/imem_fetch_unit_fifo.sv
// Small synchronous FIFO of {pc, inst}; accepts push and pop in the same
// cycle even when full, and flush empties it regardless of push/pop.
module fetch_fifo
    import imem_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wr_entry,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output fetch_entry_t             head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    // Pointer and occupancy update; flush wins over everything else.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q < FULL_CNT) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head       = head_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction fetch sequencer: owns the pc, reads one word per cycle from a
// combinational-read memory, buffers words for decode, handles redirects and
// flags illegal fetch addresses.
module imem_fetch_unit
    import imem_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                MEM_BYTES  = MEM_BYTES_DEFAULT,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_pc,
    output logic              busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;

    logic              push, pop, flush, slot_free;
    logic [CNT_W-1:0]  count;
    logic              head_valid;
    fetch_entry_t      head, wr_entry;

    assign pop       = head_valid && inst_ready;
    assign slot_free = (count < FULL_CNT) || pop;
    assign wr_entry  = '{pc: pc_q, inst: imem_data};

    // Next-state, pc and fault logic; redirect outranks start and the check.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        if (state_q != ST_IDLE && redirect_valid) begin
            flush   = 1'b1;
            pc_d    = redirect_pc;
            fault_d = 1'b0;
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_FETCH;
                        pc_d    = RESET_PC;
                    end
                end
                ST_FETCH: begin
                    if (slot_free) begin
                        if (fetch_addr_legal(pc_q, MEM_BYTES)) begin
                            push = 1'b1;
                            pc_d = pc_q + ADDR_W'(4);
                        end else begin
                            fault_d    = 1'b1;
                            fault_pc_d = pc_q;
                            state_d    = ST_FAULT;
                        end
                    end
                end
                ST_FAULT: ;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .wr_entry   (wr_entry),
        .count      (count),
        .head_valid (head_valid),
        .head       (head)
    );

    assign imem_addr  = pc_q;
    assign inst_valid = head_valid;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;
    assign fault      = fault_q;
    assign fault_pc   = fault_pc_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit: stimulus queues expected deliveries,
// a negedge monitor compares every accepted instruction against the queue.
module tb_imem_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fault;
    logic [31:0] fault_pc;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    // Memory preload: word k at byte address 4k holds 0x1000_0000 + k.
    assign imem_data = (imem_addr[1:0] == 2'b00 && imem_addr <= 32'd508)
                       ? 32'h1000_0000 + (imem_addr >> 2) : 32'hDEAD_BEEF;

    imem_fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(512), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc),
        .fault(fault), .fault_pc(fault_pc), .busy(busy)
    );

    // Monitor: every accepted instruction must match the next expectation.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && inst_valid && inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got pc=%h inst=%h, expected no delivery", inst_pc, inst);
            end else begin
                e = exp_q.pop_front();
                if ({inst_pc, inst} !== e) begin
                    errors++;
                    $display("FAIL pop_data: got pc=%h inst=%h, expected pc=%h inst=%h",
                             inst_pc, inst, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] pc, input logic [31:0] word);
        exp_q.push_back({pc, word});
    endtask

    task automatic end_scenario(input string name);
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

        // Reset values
        do_reset();
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Streaming: ten words back to back from cycle 2
        do_reset();
        expect_word(32'h00, 32'h1000_0000); expect_word(32'h04, 32'h1000_0001);
        expect_word(32'h08, 32'h1000_0002); expect_word(32'h0C, 32'h1000_0003);
        expect_word(32'h10, 32'h1000_0004); expect_word(32'h14, 32'h1000_0005);
        expect_word(32'h18, 32'h1000_0006); expect_word(32'h1C, 32'h1000_0007);
        expect_word(32'h20, 32'h1000_0008); expect_word(32'h24, 32'h1000_0009);
        inst_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;                                     // cycle 1
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_imem_addr", imem_addr, 32'h0);
        chk("start_c1_invalid", 32'(inst_valid), 32'd0);
        tick();                                                   // cycle 2
        chk("stream_c2_valid", 32'(inst_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i < 9) chk("stream_no_gap", 32'(inst_valid), 32'd1);
        end
        inst_ready = 1'b0;                                        // cycle 12
        end_scenario("stream_all_delivered");

        // Backpressure: ready low cycles 3..6
        do_reset();
        expect_word(32'h00, 32'h1000_0000); expect_word(32'h04, 32'h1000_0001);
        expect_word(32'h08, 32'h1000_0002); expect_word(32'h0C, 32'h1000_0003);
        expect_word(32'h10, 32'h1000_0004); expect_word(32'h14, 32'h1000_0005);
        expect_word(32'h18, 32'h1000_0006); expect_word(32'h1C, 32'h1000_0007);
        expect_word(32'h20, 32'h1000_0008); expect_word(32'h24, 32'h1000_0009);
        expect_word(32'h28, 32'h1000_000A); expect_word(32'h2C, 32'h1000_000B);
        inst_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;                                     // cycle 1
        tick();                                                   // cycle 2
        tick(); inst_ready = 1'b0;                                // cycle 3
        for (int c = 4; c <= 6; c++) begin
            tick();
            chk("bp_pc_frozen", imem_addr, 32'h0C);
            chk("bp_head_pc", inst_pc, 32'h04);
            chk("bp_valid", 32'(inst_valid), 32'd1);
        end
        tick(); inst_ready = 1'b1;                                // cycle 7
        chk("bp_resume_addr", imem_addr, 32'h0C);
        for (int i = 0; i < 11; i++) tick();
        inst_ready = 1'b0;                                        // cycle 18
        end_scenario("bp_all_delivered");

        // Redirect to 0x40 at cycle 5 coinciding with a pop
        do_reset();
        expect_word(32'h00, 32'h1000_0000); expect_word(32'h04, 32'h1000_0001);
        expect_word(32'h08, 32'h1000_0002); expect_word(32'h0C, 32'h1000_0003);
        expect_word(32'h40, 32'h1000_0010); expect_word(32'h44, 32'h1000_0011);
        expect_word(32'h48, 32'h1000_0012);
        inst_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;                                     // cycle 1
        tick(); tick(); tick();                                   // cycle 4
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h40;      // cycle 5
        tick(); redirect_valid = 1'b0;                            // cycle 6
        chk("redir_c6_invalid", 32'(inst_valid), 32'd0);
        chk("redir_c6_addr", imem_addr, 32'h40);
        tick();                                                   // cycle 7
        chk("redir_c7_valid", 32'(inst_valid), 32'd1);
        chk("redir_c7_inst", inst, 32'h1000_0010);
        chk("redir_c7_pc", inst_pc, 32'h40);
        tick(); tick();                                           // cycle 9
        tick(); inst_ready = 1'b0;                                // cycle 10
        end_scenario("redir_all_delivered");

        // Range fault: redirect to last word, next fetch at 0x200 faults
        do_reset();
        expect_word(32'h000, 32'h1000_0000); expect_word(32'h1FC, 32'h1000_007F);
        expect_word(32'h000, 32'h1000_0000); expect_word(32'h004, 32'h1000_0001);
        inst_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;                                     // cycle 1
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h1FC;     // cycle 2
        tick(); redirect_valid = 1'b0;                            // cycle 3
        chk("range_c3_invalid", 32'(inst_valid), 32'd0);
        tick();                                                   // cycle 4
        chk("range_last_inst", inst, 32'h1000_007F);
        chk("range_fault_not_yet", 32'(fault), 32'd0);
        tick();                                                   // cycle 5
        chk("range_fault", 32'(fault), 32'd1);
        chk("range_fault_pc", fault_pc, 32'h200);
        chk("range_no_push", 32'(inst_valid), 32'd0);
        chk("range_busy", 32'(busy), 32'd1);
        tick();                                                   // cycle 6
        chk("range_fault_hold", 32'(fault), 32'd1);
        chk("range_idle_addr", imem_addr, 32'h200);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick(); redirect_valid = 1'b0;                            // cycle 7
        chk("range_fault_cleared", 32'(fault), 32'd0);
        chk("range_resume_addr", imem_addr, 32'h0);
        tick(); tick();                                           // cycle 9
        tick(); inst_ready = 1'b0;                                // cycle 10
        end_scenario("range_all_delivered");

        // Misaligned fault: redirect to 0x22 alongside a pop
        do_reset();
        expect_word(32'h00, 32'h1000_0000); expect_word(32'h04, 32'h1000_0001);
        inst_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;                                     // cycle 1
        tick();                                                   // cycle 2
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h22;      // cycle 3
        tick(); redirect_valid = 1'b0;                            // cycle 4
        chk("mis_c4_invalid", 32'(inst_valid), 32'd0);
        chk("mis_c4_addr", imem_addr, 32'h22);
        tick();                                                   // cycle 5
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_fault_pc", fault_pc, 32'h22);
        chk("mis_no_push", 32'(inst_valid), 32'd0);
        tick();                                                   // cycle 6
        chk("mis_still_empty", 32'(inst_valid), 32'd0);
        chk("mis_pc_hold", imem_addr, 32'h22);
        end_scenario("mis_all_delivered");

        // Reset mid-stream with two entries buffered; start during rst ignored
        do_reset();
        start = 1'b1;
        tick(); start = 1'b0;                                     // cycle 1
        tick(); tick();                                           // cycle 3
        chk("mid_full_valid", 32'(inst_valid), 32'd1);
        chk("mid_full_addr", imem_addr, 32'h08);
        rst = 1'b1; start = 1'b1;
        tick();                                                   // cycle 4
        chk("mid_rst_valid", 32'(inst_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_inst_pc", inst_pc, 32'h0);
        rst = 1'b0; start = 1'b0;
        tick();                                                   // cycle 5
        chk("mid_start_ignored", 32'(busy), 32'd0);
        chk("mid_still_empty", 32'(inst_valid), 32'd0);
        end_scenario("mid_no_delivery");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
